// File: rtl/uart_line_pkg.sv
// Shared constants and state encoding for the UART line-editing buffer.
package uart_line_pkg;

   localparam logic [7:0] CR  = 8'h0D;
   localparam logic [7:0] LF  = 8'h0A;
   localparam logic [7:0] BS  = 8'h08;
   localparam logic [7:0] DEL = 8'h7F;

   typedef enum logic [2:0] {
      StCollect,
      StFetch,
      StSend,
      StSendCr,
      StSendLf
   } state_e;

endpackage

// File: rtl/line_ram.sv
// DEPTH x 8 line memory: synchronous write, registered read (iCE40 BRAM friendly).
module line_ram #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk_48mhz,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk_48mhz) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/uart_line_buffer.sv
// Line-editing echo stage: collects bytes with backspace editing, replays the line plus CR LF.
module uart_line_buffer
   import uart_line_pkg::*;
#(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk_48mhz,
   input  logic          reset_n,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [7:0]    out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          line_done,
   output logic [AW:0]   line_len
);

   localparam int unsigned LenW = AW + 1;

   state_e          state_q, state_d;
   logic [AW:0]     line_len_q, line_len_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic            in_ready_q;
   logic            done_q, done_d;

   logic            ram_we;
   logic [AW-1:0]   ram_waddr;
   logic [AW-1:0]   ram_raddr;
   logic [7:0]      ram_rdata;

   line_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_line_ram (
      .clk_48mhz (clk_48mhz),
      .we        (ram_we),
      .waddr     (ram_waddr),
      .wdata     (in_data),
      .raddr     (ram_raddr),
      .rdata     (ram_rdata)
   );

   always_comb begin
      state_d    = state_q;
      line_len_d = line_len_q;
      rd_d       = rd_q;
      done_d     = 1'b0;
      ram_we     = 1'b0;
      ram_waddr  = line_len_q[AW-1:0];
      ram_raddr  = rd_q;

      case (state_q)
         StCollect: begin
            if (in_valid && in_ready_q) begin
               if (in_data == CR) begin
                  state_d = (line_len_q != '0) ? StFetch : StSendCr;
               end else if (in_data == BS || in_data == DEL) begin
                  if (line_len_q != '0) begin
                     line_len_d = line_len_q - LenW'(1);
                  end
               end else if (in_data != LF) begin
                  ram_we     = 1'b1;
                  line_len_d = line_len_q + LenW'(1);
                  // Buffer just became full: replay as if CR had arrived.
                  if (line_len_q == LenW'(DEPTH - 1)) begin
                     state_d = StFetch;
                  end
               end
            end
         end
         StFetch: begin
            ram_raddr = '0;
            rd_d      = '0;
            state_d   = StSend;
         end
         StSend: begin
            // Read address runs one ahead on a handshake so the next byte is ready next cycle.
            if (out_ready) begin
               ram_raddr = rd_q + 1'b1;
               rd_d      = rd_q + 1'b1;
               if ({1'b0, rd_q} == line_len_q - LenW'(1)) begin
                  state_d = StSendCr;
               end
            end
         end
         StSendCr: begin
            if (out_ready) begin
               state_d = StSendLf;
            end
         end
         StSendLf: begin
            if (out_ready) begin
               done_d     = 1'b1;
               line_len_d = '0;
               state_d    = StCollect;
            end
         end
         default: state_d = StCollect;
      endcase
   end

   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StCollect;
         line_len_q <= '0;
         rd_q       <= '0;
         in_ready_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         line_len_q <= line_len_d;
         rd_q       <= rd_d;
         in_ready_q <= (state_d == StCollect);
         done_q     <= done_d;
      end
   end

   always_comb begin
      out_data = 8'h00;
      case (state_q)
         StSend:   out_data = ram_rdata;
         StSendCr: out_data = CR;
         StSendLf: out_data = LF;
         default:  out_data = 8'h00;
      endcase
   end

   assign out_valid = (state_q == StSend) || (state_q == StSendCr) || (state_q == StSendLf);
   assign in_ready  = in_ready_q;
   assign line_done = done_q;
   assign line_len  = line_len_q;

endmodule

// File: tb/tb_uart_line_buffer.sv
// Self-checking bench for uart_line_buffer: queue-based line model plus directed scenarios.
module tb_uart_line_buffer;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned AW    = $clog2(DEPTH);

   logic          clk_48mhz = 1'b0;
   logic          reset_n;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    out_data;
   logic          out_valid;
   logic          out_ready;
   logic          line_done;
   logic [AW:0]   line_len;

   uart_line_buffer #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clk_48mhz (clk_48mhz),
      .reset_n   (reset_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .line_done (line_done),
      .line_len  (line_len)
   );

   always #5 clk_48mhz = ~clk_48mhz;

   int total = 0;
   int bad   = 0;

   // Model state: bytes of the current line, bytes still owed downstream, bytes seen.
   logic [7:0] line_m[$];
   logic [7:0] exp_q[$];
   logic [7:0] got[$];
   logic [7:0] want[$];
   int  done_cnt = 0;
   bit  done_exp = 0;
   bit  prev_stall = 0;
   logic [7:0] prev_data = 8'h00;
   int  gap = 0;
   bit  fresh = 1;
   bit  rand_mode = 0;
   bit  ready_level = 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_in(input logic [7:0] b);
      if (b == 8'h0D) begin
         foreach (line_m[i]) exp_q.push_back(line_m[i]);
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
      end else if (b == 8'h08 || b == 8'h7F) begin
         if (line_m.size() > 0) void'(line_m.pop_back());
      end else if (b != 8'h0A) begin
         line_m.push_back(b);
         if (line_m.size() == DEPTH) begin
            foreach (line_m[i]) exp_q.push_back(line_m[i]);
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
         end
      end
   endtask

   // Compare process: sampled mid-cycle, transfers applied to the model for the next edge.
   always @(negedge clk_48mhz) begin
      bit exp_ready;
      if (!reset_n) begin
         check("rst_out_valid", 32'(out_valid), 0);
         check("rst_in_ready", 32'(in_ready), 0);
         check("rst_line_len", 32'(line_len), 0);
         line_m.delete();
         exp_q.delete();
         fresh = 1;
         prev_stall = 0;
         done_exp = 0;
         gap = 0;
      end else begin
         exp_ready = (exp_q.size() == 0) && !fresh;
         check("in_ready", 32'(in_ready), 32'(exp_ready));
         check("line_len", 32'(line_len), 32'(line_m.size()));
         check("line_done", 32'(line_done), 32'(done_exp));
         done_exp = 0;
         if (prev_stall) check("stall_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, prev_data});
         if (out_valid) begin
            if (exp_q.size() == 0) check("out_valid_idle", 32'(out_valid), 0);
            else check("out_data", 32'(out_data), 32'(exp_q[0]));
            gap = 0;
         end else if (exp_q.size() > 0) begin
            gap++;
            check("out_gap", 32'(gap <= 1), 1);
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         if (out_valid && out_ready && exp_q.size() > 0) begin
            got.push_back(out_data);
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
               line_m.delete();
               done_exp = 1;
               done_cnt++;
            end
         end
         if (in_valid && exp_ready) model_in(in_data);
         fresh = 0;
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk_48mhz);
         #1;
         out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_level;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = b;
      forever begin
         @(negedge clk_48mhz);
         if (in_ready) break;
         n++;
         if (n > 500) begin
            check("send_timeout", 1, 0);
            break;
         end
      end
      @(posedge clk_48mhz);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clk_48mhz);
         n++;
      end
      check("idle_timeout", 32'(exp_q.size()), 0);
      @(negedge clk_48mhz);
      @(posedge clk_48mhz);
      #1;
   endtask

   task automatic check_got(input string name);
      int n;
      check({name, "_len"}, 32'(got.size()), 32'(want.size()));
      n = (got.size() < want.size()) ? got.size() : want.size();
      for (int i = 0; i < n; i++) check(name, 32'(got[i]), 32'(want[i]));
      got.delete();
      want.delete();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk_48mhz);
      #2;
      reset_n = 1'b1;
   endtask

   initial begin
      int d0;
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #3;
      check("reset_out_valid", 32'(out_valid), 0);
      check("reset_out_data", 32'(out_data), 0);
      check("reset_in_ready", 32'(in_ready), 0);
      check("reset_line_done", 32'(line_done), 0);
      do_reset();
      check("in_ready_at_release", 32'(in_ready), 0);
      @(posedge clk_48mhz);
      #1;
      check("in_ready_first_edge", 32'(in_ready), 1);

      // "Hi" CR: FETCH gap, then H i CR LF back to back, then line_done.
      d0 = done_cnt;
      send_byte(8'h48);
      send_byte(8'h69);
      check("hi_len", 32'(line_len), 2);
      send_byte(8'h0D);
      @(negedge clk_48mhz);
      check("hi_fetch_gap", 32'(out_valid), 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_48mhz);
         check("hi_stream_valid", 32'(out_valid), 1);
      end
      @(negedge clk_48mhz);
      check("hi_line_done", 32'(line_done), 1);
      wait_idle();
      want.push_back(8'h48); want.push_back(8'h69);
      want.push_back(8'h0D); want.push_back(8'h0A);
      check_got("hi_stream");
      check("hi_done_cnt", 32'(done_cnt - d0), 1);
      check("hi_len_clear", 32'(line_len), 0);

      // Backspace editing and DEL on an empty line.
      send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
      check("abc_len", 32'(line_len), 3);
      send_byte(8'h08);
      check("bs_len", 32'(line_len), 2);
      send_byte(8'h64);
      send_byte(8'h0D);
      wait_idle();
      want.push_back(8'h61); want.push_back(8'h62); want.push_back(8'h64);
      want.push_back(8'h0D); want.push_back(8'h0A);
      check_got("abd_stream");
      send_byte(8'h7F);
      check("del_empty_len", 32'(line_len), 0);

      // Full buffer triggers replay without CR.
      d0 = done_cnt;
      for (int i = 0; i < DEPTH; i++) send_byte(8'(i));
      wait_idle();
      for (int i = 0; i < DEPTH; i++) want.push_back(8'(i));
      want.push_back(8'h0D); want.push_back(8'h0A);
      check_got("full_stream");
      check("full_done_cnt", 32'(done_cnt - d0), 1);

      // Random downstream stalls while input is held during replay.
      rand_mode = 1;
      send_byte(8'h78); send_byte(8'h79); send_byte(8'h0D);
      send_byte(8'h71); send_byte(8'h72); send_byte(8'h0D);
      wait_idle();
      rand_mode = 0;
      want.push_back(8'h78); want.push_back(8'h79);
      want.push_back(8'h0D); want.push_back(8'h0A);
      want.push_back(8'h71); want.push_back(8'h72);
      want.push_back(8'h0D); want.push_back(8'h0A);
      check_got("stall_stream");

      // Lone CR gives CR LF immediately; lone LF gives nothing.
      @(posedge clk_48mhz);
      #1;
      send_byte(8'h0D);
      @(negedge clk_48mhz);
      check("lone_cr_valid", 32'(out_valid), 1);
      check("lone_cr_data", 32'(out_data), 32'h0D);
      wait_idle();
      send_byte(8'h0A);
      repeat (5) @(negedge clk_48mhz);
      want.push_back(8'h0D); want.push_back(8'h0A);
      check_got("lone_stream");
      check("lone_lf_len", 32'(line_len), 0);

      // Reset in the middle of a stalled replay.
      ready_level = 0;
      @(posedge clk_48mhz);
      #1;
      send_byte(8'h57); send_byte(8'h58); send_byte(8'h59); send_byte(8'h5A);
      send_byte(8'h0D);
      repeat (3) @(negedge clk_48mhz);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_out_valid", 32'(out_valid), 0);
      check("async_in_ready", 32'(in_ready), 0);
      check("async_line_len", 32'(line_len), 0);
      ready_level = 1;
      got.delete();
      repeat (2) @(posedge clk_48mhz);
      #2;
      reset_n = 1'b1;
      @(posedge clk_48mhz);
      #1;
      check("post_rst_in_ready", 32'(in_ready), 1);
      send_byte(8'h6F); send_byte(8'h6B); send_byte(8'h0D);
      wait_idle();
      want.push_back(8'h6F); want.push_back(8'h6B);
      want.push_back(8'h0D); want.push_back(8'h0A);
      check_got("post_rst_stream");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running expected stopped");
      $fatal(1, "watchdog");
   end

endmodule
